ps2_scancode_decoder: RTL and testbench
=======================================

Name: ps2_scancode_decoder

Overview:
- Sits directly downstream of the PS/2 keyboard interface and consumes its 8-bit `code` output.
- Assembles PS/2 Set-2 byte sequences into key events: plain, E0-extended, F0-break, E0 F0 extended-break.
- Queues events in a small show-ahead FIFO for the game/control logic.
- Keeps a live held/released bitmap of the gameplay keys.

Parameters:
- FIFO_DEPTH, 8, number of queued events; power of two, 2..64.
- TIMEOUT_CYCLES, 2500000, CLK cycles (50 ms at 50 MHz) a partial sequence may wait for its next byte before being abandoned.
- SKIP_LEN, 7, number of bytes discarded after a 0xE1 (Pause) prefix.

Ports:
- CLK  in  1  system clock, 50 MHz.
- reset  in  1  asynchronous, active-low reset; 0 = reset.
- code  in  8  byte from keyboard interface; nonzero for exactly one CLK cycle per received byte, 0x00 otherwise (0x00 = no byte).
- evt_valid  out  1  FIFO not empty.
- evt_data  out  10  head event {extended, released, scancode[7:0]}; valid while evt_valid=1.
- evt_ready  in  1  pop handshake; head is removed on a cycle with evt_valid & evt_ready.
- key_state  out  7  held bitmap {esc, enter, space, right, left, down, up}; 1 = held.
- overflow  out  1  sticky; set when an event is dropped because the FIFO is full.
- fifo_count  out  log2(FIFO_DEPTH)+1  current occupancy.

Behaviour:
- Reset (reset=0, asynchronous):
  - FSM returns to IDLE; timeout counter, skip counter, FIFO pointers and count are cleared.
  - key_state=0, overflow=0, evt_valid=0, evt_data=0.
  - A sequence that is partially assembled when reset asserts is discarded.
- Byte strobe: a byte is accepted on any cycle with code != 0x00. There is no other qualifier.
- FSM states and transitions:
  - IDLE: E0 -> EXT; F0 -> BRK; E1 -> SKIP (skip_cnt=SKIP_LEN); any other code -> emit {0,0,code}.
  - EXT: F0 -> EXTBRK; E0 -> stay in EXT; any other code -> emit {1,0,code}, go to IDLE.
  - BRK: any code except E0/F0 -> emit {0,1,code}, go to IDLE. E0 or F0 -> protocol error: go to IDLE, no event.
  - EXTBRK: any code except E0/F0 -> emit {1,1,code}, go to IDLE. E0 or F0 -> protocol error: go to IDLE, no event.
  - SKIP: each byte decrements skip_cnt; when it reaches 0 -> IDLE. No events are emitted.
- Control bytes 0xAA, 0xFA, 0xEE, 0xFC, 0xFD, 0xFE, 0xFF:
  - Dropped in every state except SKIP; force the FSM to IDLE with no event.
  - In SKIP they are counted like any other byte.
- Timeout:
  - The counter clears on every accepted byte and increments each cycle while the FSM is not IDLE.
  - When it reaches TIMEOUT_CYCLES-1, the FSM goes to IDLE and the partial sequence is discarded.
  - If the timeout cycle and a byte strobe coincide, the byte wins: it is processed against the pre-timeout state.
- Emit timing:
  - The event is pushed at the clock edge following the completing byte.
  - With the FIFO empty, evt_valid rises 1 cycle after the completing byte's strobe cycle (registered, latency 1).
- key_state updates on the same edge as the push, regardless of FIFO fullness.
  - Key map: up=E0 75, down=E0 72, left=E0 6B, right=E0 74, space=29, enter=5A, esc=76.
  - A make event sets the bit; a break event clears it. An extended flag mismatch means no match (e.g. plain 75 does not affect up).
- FIFO:
  - Show-ahead; evt_data is the head entry whenever evt_valid=1.
  - Push and pop in the same cycle: count is unchanged, both take effect.
  - When full, a push with no simultaneous pop drops the new event and sets overflow. A push with a simultaneous pop succeeds.
  - A pop while empty is ignored.
  - Pointers wrap modulo FIFO_DEPTH.
  - overflow clears only on reset.
- Throughput: input bytes arrive no faster than one per 250 CLK cycles, but the block must accept back-to-back strobes on consecutive cycles correctly.

Test Plan:
- Reset, then code=1C, evt_ready=0 -> evt_valid=1 on the next cycle, evt_data=0x01C, fifo_count=1; key_state=0.
- Sequence E0, 75 then E0, F0, 75 (bytes 300 cycles apart), evt_ready=1 -> events 0x275 then 0x375; key_state[0] goes 1 after the first event and back to 0 after the second.
- F0, then no byte for TIMEOUT_CYCLES -> FSM back to IDLE, no event. A following 29 -> event 0x029 (make, not break); key_state[4]=1.
- E1 14 77 E1 F0 14 F0 77, then 1C -> only 0x01C emitted; fifo_count=1.
- evt_ready=0 and 9 single-byte makes (codes 15..1D) with FIFO_DEPTH=8 -> fifo_count=8, overflow=1, evt_data=0x015.
  - Then pulse evt_ready together with a 10th push -> fifo_count stays 8.
  - Draining yields 0x016..0x01C followed by the 10th code.
- Assert reset mid-sequence after E0 F0 -> all outputs 0. After release, code=75 -> event 0x075 and key_state unchanged.

Source files
------------

// File: rtl/ps2_scancode_decoder.sv
// PS/2 Set-2 scancode assembler: turns the keyboard interface's byte strobes into
// {extended, released, code} events, queues them, and tracks held gameplay keys.
module ps2_scancode_decoder #(
    parameter int unsigned FIFO_DEPTH     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 2500000,
    parameter int unsigned SKIP_LEN       = 7
) (
    input  logic                          CLK,
    input  logic                          reset,
    input  logic [7:0]                    code,
    output logic                          evt_valid,
    output logic [9:0]                    evt_data,
    input  logic                          evt_ready,
    output logic [6:0]                    key_state,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int unsigned PW   = $clog2(FIFO_DEPTH);
    localparam int unsigned CW   = PW + 1;
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned SK_W = $clog2(SKIP_LEN + 1);

    typedef enum logic [2:0] {IDLE, EXT, BRK, EXTBRK, SKIP} state_t;

    state_t          state_q, state_d;
    logic [TO_W-1:0] to_q, to_d;
    logic [SK_W-1:0] skip_q, skip_d;
    logic [6:0]      key_q, key_d;
    logic            ovf_q, ovf_d;
    logic [PW-1:0]   wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0]   count_q, count_d;
    logic [9:0]      mem_q [FIFO_DEPTH];

    logic       byte_vld, is_ctrl, emit, ev_ext, ev_rel;
    logic       pop, full, push_ok;
    logic [6:0] key_hit;

    assign byte_vld = (code != 8'h00);
    assign is_ctrl  = code inside {8'hAA, 8'hFA, 8'hEE, 8'hFC, 8'hFD, 8'hFE, 8'hFF};

    // A byte always takes priority over the timeout firing in the same cycle.
    always_comb begin
        state_d = state_q;
        to_d    = to_q;
        skip_d  = skip_q;
        emit    = 1'b0;
        ev_ext  = 1'b0;
        ev_rel  = 1'b0;
        if (byte_vld) begin
            to_d = '0;
            if (state_q == SKIP) begin
                skip_d = skip_q - SK_W'(1);
                if (skip_d == '0) state_d = IDLE;
            end else if (is_ctrl) begin
                state_d = IDLE;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (code == 8'hE0)      state_d = EXT;
                        else if (code == 8'hF0) state_d = BRK;
                        else if (code == 8'hE1) begin
                            state_d = SKIP;
                            skip_d  = SK_W'(SKIP_LEN);
                        end else emit = 1'b1;
                    end
                    EXT: begin
                        if (code == 8'hF0)      state_d = EXTBRK;
                        else if (code != 8'hE0) begin
                            state_d = IDLE;
                            emit    = 1'b1;
                            ev_ext  = 1'b1;
                        end
                    end
                    BRK: begin
                        state_d = IDLE;
                        emit    = (code != 8'hE0) && (code != 8'hF0);
                        ev_rel  = 1'b1;
                    end
                    EXTBRK: begin
                        state_d = IDLE;
                        emit    = (code != 8'hE0) && (code != 8'hF0);
                        ev_ext  = 1'b1;
                        ev_rel  = 1'b1;
                    end
                    default: state_d = IDLE;
                endcase
            end
        end else if (state_q != IDLE) begin
            if (to_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
                state_d = IDLE;
                to_d    = '0;
            end else begin
                to_d = to_q + TO_W'(1);
            end
        end
    end

    always_comb begin
        key_hit = '0;
        case ({ev_ext, code})
            9'h175:  key_hit[0] = 1'b1;
            9'h172:  key_hit[1] = 1'b1;
            9'h16B:  key_hit[2] = 1'b1;
            9'h174:  key_hit[3] = 1'b1;
            9'h029:  key_hit[4] = 1'b1;
            9'h05A:  key_hit[5] = 1'b1;
            9'h076:  key_hit[6] = 1'b1;
            default: key_hit = '0;
        endcase
        key_d = key_q;
        if (emit) key_d = ev_rel ? (key_q & ~key_hit) : (key_q | key_hit);
    end

    always_comb begin
        pop     = (count_q != '0) && evt_ready;
        full    = (count_q == CW'(FIFO_DEPTH));
        push_ok = emit && (!full || pop);
        ovf_d   = ovf_q || (emit && full && !pop);
        wr_d    = push_ok ? wr_q + PW'(1) : wr_q;
        rd_d    = pop ? rd_q + PW'(1) : rd_q;
        count_d = count_q;
        case ({push_ok, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            to_q    <= '0;
            skip_q  <= '0;
            key_q   <= '0;
            ovf_q   <= 1'b0;
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            to_q    <= to_d;
            skip_q  <= skip_d;
            key_q   <= key_d;
            ovf_q   <= ovf_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (push_ok) mem_q[wr_q] <= {ev_ext, ev_rel, code};
    end

    assign evt_valid  = (count_q != '0);
    assign evt_data   = evt_valid ? mem_q[rd_q] : '0;
    assign key_state  = key_q;
    assign overflow   = ovf_q;
    assign fifo_count = count_q;

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Bench for ps2_scancode_decoder: directed vector table, reset-mid-sequence case,
// then random byte streams checked against a sequence-level reference model.
module tb_ps2_scancode_decoder;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned T     = 1000;
    localparam int unsigned SKIP  = 7;

    logic       CLK = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] code = 8'h00;
    logic       evt_ready = 1'b0;
    logic       evt_valid;
    logic [9:0] evt_data;
    logic [6:0] key_state;
    logic       overflow;
    logic [3:0] fifo_count;

    int n_cmp = 0;
    int n_bad = 0;

    ps2_scancode_decoder #(
        .FIFO_DEPTH(DEPTH),
        .TIMEOUT_CYCLES(T),
        .SKIP_LEN(SKIP)
    ) dut (
        .CLK(CLK),
        .reset(reset),
        .code(code),
        .evt_valid(evt_valid),
        .evt_data(evt_data),
        .evt_ready(evt_ready),
        .key_state(key_state),
        .overflow(overflow),
        .fifo_count(fifo_count)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [7:0] code;
        logic       rdy;
        int         gap;
        logic       vld;
        logic [9:0] data;
        logic [3:0] cnt;
        logic [6:0] key;
        logic       ovf;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic [7:0] c, input logic r, input int g, input logic v,
                                input logic [9:0] d, input logic [3:0] n, input logic [6:0] k,
                                input logic o);
        vec_t x;
        x.code = c; x.rdy = r; x.gap = g; x.vld = v;
        x.data = d; x.cnt = n; x.key = k; x.ovf = o;
        return x;
    endfunction

    task automatic check(input string nm, input bit raw, input logic ev, input logic [9:0] ed,
                         input logic [3:0] ec, input logic [6:0] ek, input logic eo);
        logic [22:0] act, exp;
        act = {evt_valid, (raw || evt_valid) ? evt_data : 10'h000, fifo_count, key_state, overflow};
        exp = {ev, (raw || ev) ? ed : 10'h000, ec, ek, eo};
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got valid=%0b data=%03h count=%0d key=%07b ovf=%0b, expected valid=%0b data=%03h count=%0d key=%07b ovf=%0b",
                     nm, evt_valid, evt_data, fifo_count, key_state, overflow, ev, ed, ec, ek, eo);
        end
    endtask

    task automatic apply(input vec_t v, input int idx);
        code = v.code;
        evt_ready = v.rdy;
        @(negedge CLK);
        code = 8'h00;
        evt_ready = 1'b0;
        repeat (v.gap) @(negedge CLK);
        check($sformatf("vec%0d", idx), 1'b0, v.vld, v.data, v.cnt, v.key, v.ovf);
    endtask

    task automatic do_reset(input string nm);
        @(negedge CLK);
        reset = 1'b0;
        code = 8'h00;
        evt_ready = 1'b0;
        #1;
        check(nm, 1'b1, 1'b0, 10'h000, 4'd0, 7'd0, 1'b0);
        repeat (2) @(negedge CLK);
        reset = 1'b1;
    endtask

    // ---------------- reference model (byte-sequence grammar) ----------------
    logic [7:0] pend[$];
    logic [9:0] mq[$];
    int         skip_left;
    longint     cyc, last_cyc;
    logic [6:0] mkey;
    logic       movf;
    logic [8:0] kid [7] = '{9'h175, 9'h172, 9'h16B, 9'h174, 9'h029, 9'h05A, 9'h076};
    logic [7:0] ctrl_list [7] = '{8'hAA, 8'hFA, 8'hEE, 8'hFC, 8'hFD, 8'hFE, 8'hFF};

    function automatic bit is_ctrl_b(input logic [7:0] b);
        for (int i = 0; i < 7; i++) if (ctrl_list[i] == b) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit pend_has(input logic [7:0] b);
        foreach (pend[i]) if (pend[i] == b) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_init();
        pend.delete(); mq.delete();
        skip_left = 0; cyc = 0; last_cyc = 0; mkey = '0; movf = 1'b0;
    endtask

    task automatic model_byte(input logic [7:0] b, output bit emit, output logic [9:0] ev);
        emit = 1'b0;
        ev = '0;
        if ((pend.size() != 0 || skip_left != 0) && (cyc - last_cyc > longint'(T))) begin
            pend.delete();
            skip_left = 0;
        end
        last_cyc = cyc;
        if (skip_left != 0) begin
            skip_left--;
        end else if (is_ctrl_b(b)) begin
            pend.delete();
        end else if (pend.size() == 0 && b == 8'hE1) begin
            skip_left = SKIP;
        end else if (b == 8'hE0 || b == 8'hF0) begin
            if (pend_has(8'hF0)) pend.delete();
            else if (!(b == 8'hE0 && pend_has(8'hE0))) pend.push_back(b);
        end else begin
            ev = {pend_has(8'hE0), pend_has(8'hF0), b};
            emit = 1'b1;
            pend.delete();
        end
    endtask

    task automatic model_cycle(input logic [7:0] b, input bit rdy);
        bit emit;
        logic [9:0] ev, tmp;
        emit = 1'b0;
        ev = '0;
        if (b != 8'h00) model_byte(b, emit, ev);
        if (rdy && mq.size() != 0) tmp = mq.pop_front();
        if (emit) begin
            for (int i = 0; i < 7; i++)
                if ({ev[9], ev[7:0]} == kid[i]) mkey[i] = ~ev[8];
            if (mq.size() < DEPTH) mq.push_back(ev);
            else movf = 1'b1;
        end
        cyc++;
    endtask

    function automatic logic [7:0] rand_byte();
        case ($urandom_range(0, 9))
            0:       return 8'hE0;
            1, 2:    return 8'hF0;
            3:       return 8'hE1;
            4:       return ctrl_list[$urandom_range(0, 6)];
            5, 6:    return kid[$urandom_range(0, 6)][7:0];
            default: return 8'($urandom_range(1, 255));
        endcase
    endfunction

    initial begin
        logic [7:0] e1seq [8] = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
        logic [9:0] drain [7] = '{10'h017, 10'h018, 10'h019, 10'h01A, 10'h01B, 10'h01C, 10'h01E};
        logic [7:0] b;
        bit         r;
        int         wait_left;

        // Basic make, extended make/break, timeout-abandoned break
        tbl.push_back(mk(8'h1C, 0, 0,   1, 10'h01C, 1, 7'h00, 0));
        tbl.push_back(mk(8'h00, 1, 0,   0, 10'h000, 0, 7'h00, 0));
        tbl.push_back(mk(8'hE0, 0, 299, 0, 10'h000, 0, 7'h00, 0));
        tbl.push_back(mk(8'h75, 0, 0,   1, 10'h275, 1, 7'h01, 0));
        tbl.push_back(mk(8'h00, 1, 0,   0, 10'h000, 0, 7'h01, 0));
        tbl.push_back(mk(8'hE0, 0, 299, 0, 10'h000, 0, 7'h01, 0));
        tbl.push_back(mk(8'hF0, 0, 299, 0, 10'h000, 0, 7'h01, 0));
        tbl.push_back(mk(8'h75, 0, 0,   1, 10'h375, 1, 7'h00, 0));
        tbl.push_back(mk(8'h00, 1, 0,   0, 10'h000, 0, 7'h00, 0));
        tbl.push_back(mk(8'hF0, 0, T+5, 0, 10'h000, 0, 7'h00, 0));
        tbl.push_back(mk(8'h29, 0, 0,   1, 10'h029, 1, 7'h10, 0));
        tbl.push_back(mk(8'h00, 1, 0,   0, 10'h000, 0, 7'h10, 0));
        // Pause sequence is swallowed whole
        for (int i = 0; i < 8; i++) tbl.push_back(mk(e1seq[i], 0, 4, 0, 10'h000, 0, 7'h10, 0));
        tbl.push_back(mk(8'h1C, 0, 0,   1, 10'h01C, 1, 7'h10, 0));
        tbl.push_back(mk(8'h00, 1, 0,   0, 10'h000, 0, 7'h10, 0));
        // Timeout boundary: T cycles apart survives, T+1 is abandoned
        tbl.push_back(mk(8'hE0, 0, T-1, 0, 10'h000, 0, 7'h10, 0));
        tbl.push_back(mk(8'h75, 0, 0,   1, 10'h275, 1, 7'h11, 0));
        tbl.push_back(mk(8'h00, 1, 0,   0, 10'h000, 0, 7'h11, 0));
        tbl.push_back(mk(8'hE0, 0, T,   0, 10'h000, 0, 7'h11, 0));
        tbl.push_back(mk(8'h74, 0, 0,   1, 10'h074, 1, 7'h11, 0));
        tbl.push_back(mk(8'h00, 1, 0,   0, 10'h000, 0, 7'h11, 0));
        // Back-to-back strobes, protocol error, control byte, extended break
        tbl.push_back(mk(8'hE0, 0, 0,   0, 10'h000, 0, 7'h11, 0));
        tbl.push_back(mk(8'h72, 0, 0,   1, 10'h272, 1, 7'h13, 0));
        tbl.push_back(mk(8'h00, 1, 0,   0, 10'h000, 0, 7'h13, 0));
        tbl.push_back(mk(8'hF0, 0, 0,   0, 10'h000, 0, 7'h13, 0));
        tbl.push_back(mk(8'hE0, 0, 0,   0, 10'h000, 0, 7'h13, 0));
        tbl.push_back(mk(8'h5A, 0, 0,   1, 10'h05A, 1, 7'h33, 0));
        tbl.push_back(mk(8'h00, 1, 0,   0, 10'h000, 0, 7'h33, 0));
        tbl.push_back(mk(8'hE0, 0, 0,   0, 10'h000, 0, 7'h33, 0));
        tbl.push_back(mk(8'hFA, 0, 0,   0, 10'h000, 0, 7'h33, 0));
        tbl.push_back(mk(8'h6B, 0, 0,   1, 10'h06B, 1, 7'h33, 0));
        tbl.push_back(mk(8'h00, 1, 0,   0, 10'h000, 0, 7'h33, 0));
        tbl.push_back(mk(8'hE0, 0, 0,   0, 10'h000, 0, 7'h33, 0));
        tbl.push_back(mk(8'hF0, 0, 0,   0, 10'h000, 0, 7'h33, 0));
        tbl.push_back(mk(8'h72, 0, 0,   1, 10'h372, 1, 7'h31, 0));
        tbl.push_back(mk(8'h00, 1, 0,   0, 10'h000, 0, 7'h31, 0));
        // Fill past full, then push+pop on a full FIFO, then drain
        for (int i = 0; i < 8; i++)
            tbl.push_back(mk(8'(8'h15 + i), 0, 1, 1, 10'h015, 4'(i + 1), 7'h31, 0));
        tbl.push_back(mk(8'h1D, 0, 1,   1, 10'h015, 8, 7'h31, 1));
        tbl.push_back(mk(8'h1E, 1, 0,   1, 10'h016, 8, 7'h31, 1));
        for (int i = 0; i < 7; i++)
            tbl.push_back(mk(8'h00, 1, 0, 1, drain[i], 4'(7 - i), 7'h31, 1));
        tbl.push_back(mk(8'h00, 1, 0,   0, 10'h000, 0, 7'h31, 1));

        do_reset("reset_initial");
        foreach (tbl[i]) apply(tbl[i], i);

        // Reset while an extended break is half assembled
        apply(mk(8'h1C, 0, 0, 1, 10'h01C, 1, 7'h31, 1), 900);
        apply(mk(8'hE0, 0, 0, 1, 10'h01C, 1, 7'h31, 1), 901);
        apply(mk(8'hF0, 0, 0, 1, 10'h01C, 1, 7'h31, 1), 902);
        do_reset("reset_midseq");
        @(negedge CLK);
        apply(mk(8'h75, 0, 0, 1, 10'h075, 1, 7'h00, 0), 903);

        // Random stream against the reference model
        do_reset("reset_random");
        @(negedge CLK);
        model_init();
        wait_left = 0;
        for (int c = 0; c < 30000; c++) begin
            check("random", 1'b0, mq.size() != 0, (mq.size() != 0) ? mq[0] : 10'h000,
                  4'(mq.size()), mkey, movf);
            if (wait_left == 0) begin
                b = rand_byte();
                wait_left = ($urandom_range(0, 24) == 0) ? int'($urandom_range(T - 2, T + 1))
                                                         : int'($urandom_range(0, 30));
            end else begin
                b = 8'h00;
                wait_left--;
            end
            r = ($urandom_range(0, 2) == 0);
            code = b;
            evt_ready = r;
            model_cycle(b, r);
            @(negedge CLK);
        end
        code = 8'h00;
        evt_ready = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
